// File: rtl/alu_engine_param_pkg.sv
// Shared opcode and FSM state definitions for the parametrised per-core ALU.
package alu_engine_param_pkg;

  localparam int OPW = 4;

  // SF*/RB* keep their legacy encodings so old decode emits them, but they are now illegal.
  typedef enum logic [OPW-1:0] {
    OP_ADD         = 4'h0,
    OP_AND         = 4'h1,
    OP_MUL         = 4'h2,
    OP_SHIFT_LEFT  = 4'h3,
    OP_SHIFT_RIGHT = 4'h4,
    OP_SF0         = 4'h5,
    OP_SF1         = 4'h6,
    OP_RB0         = 4'h7,
    OP_RB1         = 4'h8,
    OP_SUB         = 4'h9,
    OP_OR          = 4'hA,
    OP_XOR         = 4'hB,
    OP_MAC         = 4'hC,
    OP_ACC_CLR     = 4'hD
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MUL_ITER,
    DONE
  } alu_state_e;

  function automatic logic is_multicycle(opcode_e op);
    return (op == OP_MUL) || (op == OP_MAC);
  endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier: one partial product per cycle, multiplier LSB first.
module mul_shift_add
  import alu_engine_param_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               clear,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      count_q;
  logic               running_q;
  logic               done_q;

  // done pulses for one cycle right after the WIDTH-th iteration has landed in prod_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q   <= '0;
      prod_q    <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (clear) begin
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else if (start) begin
      mcand_q   <= {{WIDTH{1'b0}}, a};
      mplier_q  <= b;
      prod_q    <= '0;
      count_q   <= '0;
      running_q <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (running_q) begin
        if (mplier_q[0]) begin
          prod_q <= prod_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        count_q  <= count_q + CW'(1);
        if (count_q == LastIter) begin
          running_q <= 1'b0;
          done_q    <= 1'b1;
        end
      end
    end
  end

  assign product = prod_q;
  assign done    = done_q;

endmodule

// File: rtl/alu_engine_param.sv
// WIDTH-generic core ALU: edge-triggered start/end handshake, shift-add MUL/MAC,
// illegal-opcode flagging and synchronous flush.
module alu_engine_param
  import alu_engine_param_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [OPW-1:0]     op_sel,
  input  logic               start_op,
  input  logic               flush,
  output logic [2*WIDTH-1:0] result,
  output logic               end_op,
  output logic               err,
  output logic               busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] WidthLim = WIDTH'(WIDTH);

  alu_state_e         state_q, state_d;
  opcode_e            opCode_q, opIn;
  logic [WIDTH-1:0]   opA_q, opB_q;
  logic [2*WIDTH-1:0] acc_q, acc_d, result_q, result_d;
  logic               err_q, err_d;
  logic               startPrev_q;
  logic               accept, mulStart, mulClear, mulDone;
  logic [2*WIDTH-1:0] product, macSum, execResult, shlWide;
  logic [WIDTH:0]     addSum;
  logic [WIDTH-1:0]   subDiff;
  logic               bigShift, execErr;

  assign opIn     = opcode_e'(op_sel);
  assign accept   = (state_q == IDLE) && start_op && !startPrev_q;
  assign mulStart = accept && is_multicycle(opIn);
  assign mulClear = flush && (state_q == MUL_ITER);

  mul_shift_add #(.WIDTH(WIDTH)) uMul (
    .clk     (clk),
    .rst     (rst),
    .start   (mulStart),
    .a       (A),
    .b       (B),
    .clear   (mulClear),
    .product (product),
    .done    (mulDone)
  );

  assign addSum   = {1'b0, opA_q} + {1'b0, opB_q};
  assign subDiff  = opA_q - opB_q;
  assign bigShift = (opB_q >= WidthLim);
  assign shlWide  = {{WIDTH{1'b0}}, opA_q} << opB_q[SHW-1:0];
  assign macSum   = acc_q + product;

  always_comb begin
    execResult = '0;
    execErr    = 1'b0;
    case (opCode_q)
      OP_ADD:         execResult = {{(WIDTH-1){1'b0}}, addSum};
      OP_SUB:         execResult = {{(WIDTH-1){1'b0}}, (opA_q < opB_q), subDiff};
      OP_AND:         execResult = {{WIDTH{1'b0}}, opA_q & opB_q};
      OP_OR:          execResult = {{WIDTH{1'b0}}, opA_q | opB_q};
      OP_XOR:         execResult = {{WIDTH{1'b0}}, opA_q ^ opB_q};
      OP_SHIFT_LEFT:  execResult = bigShift ? '0 : shlWide;
      OP_SHIFT_RIGHT: execResult = bigShift ? '0 : {{WIDTH{1'b0}}, opA_q >> opB_q[SHW-1:0]};
      OP_ACC_CLR,
      OP_MUL,
      OP_MAC:         execResult = '0;
      default:        execErr    = 1'b1;
    endcase
  end

  // Results and the accumulator commit only on the edge that enters DONE; a flush blocks it.
  always_comb begin
    result_d = result_q;
    err_d    = err_q;
    acc_d    = acc_q;
    if ((state_q == EXEC) && !flush) begin
      result_d = execResult;
      err_d    = execErr;
      if (opCode_q == OP_ACC_CLR) begin
        acc_d = '0;
      end
    end else if ((state_q == MUL_ITER) && !flush && mulDone) begin
      err_d = 1'b0;
      if (opCode_q == OP_MAC) begin
        acc_d    = macSum;
        result_d = macSum;
      end else begin
        result_d = product;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = is_multicycle(opIn) ? MUL_ITER : EXEC;
        end
      end
      EXEC:     state_d = flush ? IDLE : DONE;
      MUL_ITER: begin
        if (flush) begin
          state_d = IDLE;
        end else if (mulDone) begin
          state_d = DONE;
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      startPrev_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      startPrev_q <= start_op;
      result_q    <= result_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opCode_q <= OP_ADD;
      opA_q    <= '0;
      opB_q    <= '0;
    end else if (accept) begin
      opCode_q <= opIn;
      opA_q    <= A;
      opB_q    <= B;
    end
  end

  assign result = result_q;
  assign err    = err_q;
  assign end_op = (state_q == DONE);
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_alu_engine_param.sv
// Directed self-checking bench for alu_engine_param at WIDTH=8, plus a WIDTH=16 instance.
module tb_alu_engine_param;
  import alu_engine_param_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  A, B;
  logic [3:0]  op_sel;
  logic        start_op, flush;
  logic [15:0] result;
  logic        end_op, err, busy;

  logic [15:0] A16, B16;
  logic [3:0]  op16;
  logic        start16, flush16;
  logic [31:0] result16;
  logic        end16, err16, busy16;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_engine_param #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .op_sel(op_sel), .start_op(start_op),
    .flush(flush), .result(result), .end_op(end_op), .err(err), .busy(busy)
  );

  alu_engine_param #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .A(A16), .B(B16), .op_sel(op16), .start_op(start16),
    .flush(flush16), .result(result16), .end_op(end16), .err(err16), .busy(busy16)
  );

  // Drives one op, holds start_op for 'hold' cycles, watches 24 cycles; cycle 1 follows acceptance.
  task automatic runOp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input int hold, output int lat, output int pulses,
                       output logic [15:0] res, output logic e);
    lat = -1; pulses = 0; res = '0; e = 1'b0;
    @(negedge clk);
    op_sel = op; A = a; B = b; start_op = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == hold) start_op = 1'b0;
      if (end_op === 1'b1) begin
        pulses++;
        if (lat < 0) begin
          lat = c; res = result; e = err;
        end
      end
    end
  endtask

  task automatic test_reset();
    total++; if (result !== 16'd0) begin bad++; $display("[TB] FAIL reset_result got=%0d want=0", result); end
    total++; if (end_op !== 1'b0) begin bad++; $display("[TB] FAIL reset_end_op got=%b want=0", end_op); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_add();
    int lat, pulses; logic [15:0] res; logic e;
    runOp(OP_ADD, 8'd10, 8'd7, 2, lat, pulses, res, e);
    total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL add_pulses got=%0d want=1", pulses); end
    total++; if (lat !== 2) begin bad++; $display("[TB] FAIL add_latency got=%0d want=2", lat); end
    total++; if (res !== 16'd17) begin bad++; $display("[TB] FAIL add_10_7 got=%0d want=17", res); end
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL add_err got=%b want=0", e); end
    runOp(OP_ADD, 8'd255, 8'd1, 1, lat, pulses, res, e);
    total++; if (res !== 16'd256) begin bad++; $display("[TB] FAIL add_carry got=%0d want=256", res); end
  endtask

  task automatic test_mul();
    int lat, pulses; logic [15:0] res; logic e;
    runOp(OP_MUL, 8'd4, 8'd6, 4, lat, pulses, res, e);
    total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL mul_pulses got=%0d want=1", pulses); end
    total++; if (lat !== 10) begin bad++; $display("[TB] FAIL mul_latency got=%0d want=10", lat); end
    total++; if (res !== 16'd24) begin bad++; $display("[TB] FAIL mul_4_6 got=%0d want=24", res); end
    runOp(OP_MUL, 8'd255, 8'd255, 1, lat, pulses, res, e);
    total++; if (res !== 16'd65025) begin bad++; $display("[TB] FAIL mul_255_255 got=%0d want=65025", res); end
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL mul_err got=%b want=0", e); end
  endtask

  task automatic test_mac();
    int lat, pulses; logic [15:0] res; logic e; logic [15:0] model;
    runOp(OP_ACC_CLR, 8'd3, 8'd3, 1, lat, pulses, res, e);
    total++; if (res !== 16'd0) begin bad++; $display("[TB] FAIL acc_clr got=%0d want=0", res); end
    runOp(OP_MAC, 8'd3, 8'd5, 1, lat, pulses, res, e);
    total++; if (res !== 16'd15) begin bad++; $display("[TB] FAIL mac_3_5 got=%0d want=15", res); end
    total++; if (lat !== 10) begin bad++; $display("[TB] FAIL mac_latency got=%0d want=10", lat); end
    runOp(OP_MAC, 8'd2, 8'd7, 1, lat, pulses, res, e);
    total++; if (res !== 16'd29) begin bad++; $display("[TB] FAIL mac_2_7 got=%0d want=29", res); end
    runOp(OP_ACC_CLR, 8'd0, 8'd0, 1, lat, pulses, res, e);
    model = 16'd0;
    for (int i = 1; i <= 17; i++) begin
      runOp(OP_MAC, 8'd255, 8'd255, 1, lat, pulses, res, e);
      model = model + 16'd65025;
      total++; if (res !== model) begin bad++; $display("[TB] FAIL mac_wrap_%0d got=%0d want=%0d", i, res, model); end
    end
    total++; if (res !== 16'd56849) begin bad++; $display("[TB] FAIL mac_wrap_final got=%0d want=56849", res); end
  endtask

  task automatic test_logic();
    int lat, pulses; logic [15:0] res; logic e;
    runOp(OP_SHIFT_LEFT, 8'd3, 8'd5, 1, lat, pulses, res, e);
    total++; if (res !== 16'd96) begin bad++; $display("[TB] FAIL shl_3_5 got=%0d want=96", res); end
    runOp(OP_SHIFT_LEFT, 8'd255, 8'd7, 1, lat, pulses, res, e);
    total++; if (res !== 16'd32640) begin bad++; $display("[TB] FAIL shl_255_7 got=%0d want=32640", res); end
    runOp(OP_SHIFT_RIGHT, 8'd10, 8'd2, 1, lat, pulses, res, e);
    total++; if (res !== 16'd2) begin bad++; $display("[TB] FAIL shr_10_2 got=%0d want=2", res); end
    runOp(OP_SHIFT_RIGHT, 8'd10, 8'd8, 1, lat, pulses, res, e);
    total++; if (res !== 16'd0) begin bad++; $display("[TB] FAIL shr_10_8 got=%0d want=0", res); end
    runOp(OP_SUB, 8'd5, 8'd7, 1, lat, pulses, res, e);
    total++; if (res !== 16'd510) begin bad++; $display("[TB] FAIL sub_5_7 got=%0d want=510", res); end
    runOp(OP_SUB, 8'd7, 8'd5, 1, lat, pulses, res, e);
    total++; if (res !== 16'd2) begin bad++; $display("[TB] FAIL sub_7_5 got=%0d want=2", res); end
    runOp(OP_AND, 8'hC3, 8'h5A, 1, lat, pulses, res, e);
    total++; if (res !== 16'h0042) begin bad++; $display("[TB] FAIL and got=%h want=0042", res); end
    runOp(OP_OR, 8'hC3, 8'h5A, 1, lat, pulses, res, e);
    total++; if (res !== 16'h00DB) begin bad++; $display("[TB] FAIL or got=%h want=00db", res); end
    runOp(OP_XOR, 8'hC3, 8'h5A, 1, lat, pulses, res, e);
    total++; if (res !== 16'h0099) begin bad++; $display("[TB] FAIL xor got=%h want=0099", res); end
  endtask

  task automatic test_illegal();
    int lat, pulses; logic [15:0] res; logic e;
    runOp(OP_SF1, 8'd6, 8'd2, 1, lat, pulses, res, e);
    total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL illegal_pulses got=%0d want=1", pulses); end
    total++; if (e !== 1'b1) begin bad++; $display("[TB] FAIL illegal_err got=%b want=1", e); end
    total++; if (res !== 16'd0) begin bad++; $display("[TB] FAIL illegal_result got=%0d want=0", res); end
    runOp(OP_ADD, 8'd1, 8'd1, 1, lat, pulses, res, e);
    total++; if (res !== 16'd2) begin bad++; $display("[TB] FAIL post_illegal_add got=%0d want=2", res); end
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL post_illegal_err got=%b want=0", e); end
  endtask

  // Expects result=2 and accumulator=56849 on entry; a flushed MAC must leave both untouched.
  task automatic test_flush();
    int lat, pulses; logic [15:0] res; logic e;
    for (int k = 0; k < 2; k++) begin
      pulses = 0;
      @(negedge clk);
      op_sel = (k == 0) ? OP_MUL : OP_MAC; A = 8'd100; B = 8'd100; start_op = 1'b1;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (c == 1) start_op = 1'b0;
        if (c == 4) begin
          total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL flush%0d_busy_before got=%b want=1", k, busy); end
          flush = 1'b1;
        end
        if (c == 5) begin
          flush = 1'b0;
          total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL flush%0d_busy_after got=%b want=0", k, busy); end
        end
        if (end_op === 1'b1) pulses++;
      end
      total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL flush%0d_end_op got=%0d want=0", k, pulses); end
      total++; if (result !== 16'd2) begin bad++; $display("[TB] FAIL flush%0d_result got=%0d want=2", k, result); end
    end
    runOp(OP_MAC, 8'd1, 8'd1, 1, lat, pulses, res, e);
    total++; if (res !== 16'd56850) begin bad++; $display("[TB] FAIL flush_mac_uncommitted got=%0d want=56850", res); end
  endtask

  task automatic test_reset_mid_mul();
    int pulses = 0;
    @(negedge clk);
    op_sel = OP_MUL; A = 8'd5; B = 8'd5; start_op = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) start_op = 1'b0;
    end
    #1 rst = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy got=%b want=0", busy); end
    total++; if (end_op !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_end_op got=%b want=0", end_op); end
    total++; if (result !== 16'd0) begin bad++; $display("[TB] FAIL rstmid_result got=%0d want=0", result); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_err got=%b want=0", err); end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (end_op === 1'b1) pulses++;
    end
    total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL rstmid_no_end_op got=%0d want=0", pulses); end
  endtask

  task automatic test_back_to_back();
    int lat = -1; int pulses = 0; logic [15:0] res = '0;
    @(negedge clk);
    op_sel = OP_MUL; A = 8'd4; B = 8'd6; start_op = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) start_op = 1'b0;
      if (c == 3) begin op_sel = OP_ADD; A = 8'd1; B = 8'd1; start_op = 1'b1; end
      if (c == 4) start_op = 1'b0;
      if (end_op === 1'b1) begin
        pulses++;
        if (lat < 0) begin lat = c; res = result; end
      end
    end
    total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL b2b_pulses got=%0d want=1", pulses); end
    total++; if (lat !== 10) begin bad++; $display("[TB] FAIL b2b_latency got=%0d want=10", lat); end
    total++; if (res !== 16'd24) begin bad++; $display("[TB] FAIL b2b_result got=%0d want=24", res); end
  endtask

  task automatic test_width16();
    int lat = -1; int pulses = 0; logic [31:0] res = '0; logic e = 1'b0;
    @(negedge clk);
    op16 = OP_MUL; A16 = 16'd300; B16 = 16'd300; start16 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) start16 = 1'b0;
      if (end16 === 1'b1) begin
        pulses++;
        if (lat < 0) begin lat = c; res = result16; e = err16; end
      end
    end
    total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL w16_pulses got=%0d want=1", pulses); end
    total++; if (lat !== 18) begin bad++; $display("[TB] FAIL w16_latency got=%0d want=18", lat); end
    total++; if (res !== 32'd90000) begin bad++; $display("[TB] FAIL w16_mul got=%0d want=90000", res); end
    total++; if (e !== 1'b0) begin bad++; $display("[TB] FAIL w16_err got=%b want=0", e); end
  endtask

  initial begin
    rst = 1'b0; A = '0; B = '0; op_sel = '0; start_op = 1'b0; flush = 1'b0;
    A16 = '0; B16 = '0; op16 = '0; start16 = 1'b0; flush16 = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    test_add();
    test_mul();
    test_mac();
    test_logic();
    test_illegal();
    test_flush();
    test_reset_mid_mul();
    test_back_to_back();
    test_width16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
